// File: rtl/dbgu_mem_arbiter_pkg.sv
// Shared encodings for the CPU / debug-unit memory arbiter.
// Types and constants only; no logic.
package dbgu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Counter width that still holds the value n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbgu_mem_arbiter_timeout.sv
// Transfer watchdog: counts XFER cycles, flags the last allowed one.
// Latency: expire is combinational on the current count; clear takes effect next cycle.
// Backpressure: none, the counter holds at its last value while expired.
module arb_timeout
  import dbgu_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dbgu_mem_arbiter.sv
// Two-master arbiter (CPU, debug unit) for the single memory port, with CPU halt.
// Latency: grant in IDLE, mem_req next cycle, rdy one cycle after mem_rdy (3 cycles zero-wait).
// Backpressure: requests are levels held until rdy; the memory stalls via mem_rdy, bounded by a timeout.
module dbgu_mem_arbiter
  import dbgu_mem_arbiter_pkg::*;
#(
  parameter int              ADR_W         = 32,
  parameter int              DATA_W        = 32,
  parameter int              DBG_BURST_MAX = 16,
  parameter int              TIMEOUT       = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADR_W-1:0]  dbg_adr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rdy,
  output logic              dbg_err,
  input  logic              dbg_halt,
  output logic              cpu_halted,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam int BW = $clog2(DBG_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(DBG_BURST_MAX);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic                mem_we_q, mem_we_d;
  logic [ADR_W-1:0]    mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                dbg_err_q, dbg_err_d;
  logic                cpu_halted_q, cpu_halted_d;

  logic                cpu_eligible;
  logic                cpu_starved;
  logic                cpu_inflight;
  logic                tmo_expire;
  logic [DATA_W-1:0]   rsp_data;

  assign cpu_eligible = cpu_req && !dbg_halt;
  assign cpu_starved  = cpu_eligible && (burst_q == BURST_MAX);
  assign rsp_data     = mem_rdy ? mem_rdata : ERR_DATA;

  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q != ST_XFER),
    .en     (state_q == ST_XFER),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = cpu_err_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_err_d   = dbg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!cpu_req) begin
          burst_d = '0;
        end
        if (dbg_req && !cpu_starved) begin
          state_d     = ST_XFER;
          owner_d     = OWN_DBG;
          mem_we_d    = dbg_we;
          mem_adr_d   = dbg_adr;
          mem_wdata_d = dbg_wdata;
          // Only debug grants that actually make the CPU wait count toward starvation.
          if (cpu_eligible && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
          end
        end else if (cpu_eligible) begin
          state_d     = ST_XFER;
          owner_d     = OWN_CPU;
          mem_we_d    = cpu_we;
          mem_adr_d   = cpu_adr;
          mem_wdata_d = cpu_wdata;
          burst_d     = '0;
        end
      end
      ST_XFER: begin
        if (mem_rdy || tmo_expire) begin
          state_d = ST_DONE;
          if (owner_q == OWN_DBG) begin
            dbg_rdata_d = rsp_data;
            dbg_err_d   = !mem_rdy;
          end else begin
            cpu_rdata_d = rsp_data;
            cpu_err_d   = !mem_rdy;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Halt becomes visible only once no CPU transfer will be in flight next cycle.
    cpu_inflight = (state_d != ST_IDLE) && (owner_d == OWN_CPU);
    cpu_halted_d = dbg_halt && !cpu_inflight;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      burst_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_adr_q    <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
      cpu_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      mem_we_q     <= mem_we_d;
      mem_adr_q    <= mem_adr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_err_q    <= cpu_err_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_err_q    <= dbg_err_d;
      cpu_halted_q <= cpu_halted_d;
    end
  end

  assign mem_req    = (state_q == ST_XFER);
  assign mem_we     = mem_we_q;
  assign mem_adr    = mem_adr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdy    = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign dbg_rdy    = (state_q == ST_DONE) && (owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_err    = cpu_err_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_err    = dbg_err_q;
  assign cpu_halted = cpu_halted_q;

endmodule

// File: doc/dbgu_mem_arbiter.md
Name: dbgu_mem_arbiter

Overview:
- Two-master arbiter for the single SoC memory port, shared by the CPU and the dbgu32 debug unit.
- Grants exactly one master per transfer, drives the memory handshake and returns data and a ready pulse to the owner.
- Lets the debug unit halt the CPU. Guards the memory port with a timeout and prevents CPU starvation when the CPU is not halted.

Parameters:
- ADR_W, 32, address width
- DATA_W, 32, data width
- DBG_BURST_MAX, 16, max consecutive debug grants while cpu_req is pending and not halted
- TIMEOUT, 1024, cycles of mem_req without mem_rdy before abort
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU transfer request; level, held until cpu_rdy
- cpu_we  in  1  CPU write enable
- cpu_adr  in  ADR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_rdy
- cpu_rdy  out  1  one-cycle completion pulse to CPU
- cpu_err  out  1  timeout flag, valid with cpu_rdy
- dbg_req / dbg_we / dbg_adr / dbg_wdata  in  1/1/ADR_W/DATA_W  debug-side equivalents
- dbg_rdata  out  DATA_W  debug read data, valid with dbg_rdy
- dbg_rdy  out  1  one-cycle completion pulse to debug unit
- dbg_err  out  1  timeout flag, valid with dbg_rdy
- dbg_halt  in  1  debug unit requests CPU halt
- cpu_halted  out  1  halt is effective: dbg_halt high and no CPU transfer in flight
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_adr  out  ADR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rdy  in  1  memory completion, sampled while mem_req is high

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - The burst counter and timeout counter clear.
  - Reset mid-transfer abandons it: no rdy pulse is issued.
- FSM states: IDLE, XFER, DONE.
- IDLE: arbitrate on the current cycle's requests, then register owner and mem_adr/we/wdata; go to XFER.
  - Grant order: dbg if dbg_req.
  - Exception: cpu wins if cpu_req && !dbg_halt && burst_cnt == DBG_BURST_MAX.
  - Otherwise cpu if cpu_req && !dbg_halt.
  - No request: stay in IDLE.
- XFER: mem_req=1 with registered signals held stable.
  - On mem_rdy: latch mem_rdata into the owner's rdata, err=0, go to DONE.
  - When timeout_cnt reaches TIMEOUT-1 without mem_rdy: drop mem_req, set rdata=ERR_DATA, err=1, go to DONE.
  - timeout_cnt increments every XFER cycle and clears on entry.
- DONE: owner rdy=1 for exactly this cycle, mem_req=0, return to IDLE. No arbitration occurs in DONE.
- Latency: req seen in IDLE at cycle N -> mem_req at N+1 -> mem_rdy at M -> rdy at M+1 -> IDLE at M+2. With zero-wait memory (mem_rdy at N+1), one transfer takes 3 cycles.
- Requester rules:
  - Hold req and signals until rdy. Dropping req during XFER does not cancel; the transfer completes and rdy still pulses.
  - Next request may be presented in the cycle after rdy.
  - Only the owner's rdata/err change; the non-owner's outputs hold.
- burst_cnt:
  - Increments on each dbg grant while cpu_req && !dbg_halt, saturating at DBG_BURST_MAX.
  - Clears on any cpu grant, or when cpu_req is low in IDLE.
- Halt:
  - dbg_halt rising during a CPU transfer lets it finish. cpu_halted asserts the cycle after the CPU's DONE.
  - While halted, cpu_req is ignored.
  - cpu_halted deasserts the cycle after dbg_halt falls.
- Simultaneous cpu_req and dbg_req in IDLE: dbg wins unless the starvation rule applies.

Decomposition:
- Shared include dbgu_arb_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, XFER=2'd1, DONE=2'd2)
  - owner encoding (OWN_CPU=1'b0, OWN_DBG=1'b1)
  - default ERR_DATA
- One natural sub-module, arb_timeout: load-clear/enable/expire counter of width $clog2(TIMEOUT).

Test Plan:
- CPU read alone: cpu_req, adr 32'h20000; mem_rdy after 2 cycles with rdata 32'h12345678 -> mem_req for 2 cycles; cpu_rdy pulses 1 cycle with cpu_rdata 32'h12345678, cpu_err=0; dbg outputs unchanged.
- Simultaneous cpu_req and dbg_req (dbg write 32'h05 to 32'h20000) -> dbg granted first, mem_we=1; CPU served after dbg_rdy.
- Starvation: dbg_req held high and cpu_req high for 40 transfers, DBG_BURST_MAX=16 -> grant sequence is 16 dbg, 1 cpu, 16 dbg, 1 cpu.
- Halt: dbg_halt rises mid CPU transfer -> transfer completes, cpu_rdy pulses, cpu_halted=1 next cycle; later cpu_req not granted; cpu_req granted after dbg_halt falls.
- Timeout: mem_rdy never asserts, TIMEOUT=8 -> mem_req high 8 cycles, then dbg_rdy=1, dbg_err=1, dbg_rdata=32'hDEADBEEF; next request proceeds normally.
- Reset asserted during XFER -> mem_req=0 and rdy=0 immediately; state is IDLE after release; no spurious rdy.
